en_change_capture: RTL

Parametrised multi-channel change-triggered capture register. Each channel latches its data input when its enable/tag vector differs from the last recorded value, qualified by a global mode. Every capture is counted and queued as an event on a single valid/ready output port, arbitrated round-robin. It sits between slow control/status sources and the sampling/logging fabric.

---
 rtl/en_change_capture.sv | 122 ++++++++++++
 1 files changed

// File: rtl/en_change_capture.sv
// en_change_capture: multi-channel change-triggered capture register with a
// round-robin event queue on one valid/ready output.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   d, en             per-channel data and tag vectors (channel i at i*W +: W)
//   mode              0 any change, 1 change to nonzero, 2 change to all-ones, 3 frozen
//   clr_cnt           clears capture counters and overflow flags
//   is_diff           combinational tag-change indication per channel
//   q, chg_cnt        last captured data and saturating capture count per channel
//   overflow          sticky flag: a pending event was overwritten before delivery
//   evt_*             registered event output (channel + data), valid/ready handshake
module en_change_capture #(
    parameter int CH   = 4,
    parameter int DW   = 8,
    parameter int EW   = 5,
    parameter int CNTW = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CH*DW-1:0]      d,
    input  logic [CH*EW-1:0]      en,
    input  logic [1:0]            mode,
    input  logic                  clr_cnt,
    output logic [CH-1:0]         is_diff,
    output logic [CH*DW-1:0]      q,
    output logic [CH*CNTW-1:0]    chg_cnt,
    output logic [CH-1:0]         overflow,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [$clog2(CH)-1:0] evt_ch,
    output logic [DW-1:0]         evt_data
);
    localparam int PW = $clog2(CH);

    logic [CH*EW-1:0] prev_en;
    logic [CH-1:0]    pend;
    logic [DW-1:0]    pend_data [CH];
    logic [PW-1:0]    rr_ptr;
    logic [CH-1:0]    trg;
    logic [CH-1:0]    take;
    logic [PW-1:0]    sel;
    logic [PW-1:0]    idx;
    logic             found;
    logic             load;
    int               j;

    always_comb begin
        is_diff = '0;
        trg     = '0;
        for (int i = 0; i < CH; i++) begin
            is_diff[i] = |(prev_en[i*EW +: EW] ^ en[i*EW +: EW]);
            trg[i] = (mode == 2'd0) ? is_diff[i] :
                     (mode == 2'd1) ? is_diff[i] && (|en[i*EW +: EW]) :
                     (mode == 2'd2) ? is_diff[i] && (&en[i*EW +: EW]) : 1'b0;
        end
    end

    // Round-robin search over pending channels, starting at rr_ptr.
    // Uses pend as registered, so a trigger this cycle is eligible next cycle.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < CH; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= CH) j = j - CH;
            idx = PW'(j);
            if (!found && pend[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign load = !evt_valid || evt_ready;

    always_comb begin
        take = '0;
        for (int i = 0; i < CH; i++) take[i] = load && found && (sel == PW'(i));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_en   <= '0;
            q         <= '0;
            pend      <= '0;
            chg_cnt   <= '0;
            overflow  <= '0;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_data  <= '0;
            rr_ptr    <= '0;
            for (int i = 0; i < CH; i++) pend_data[i] <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                // prev_en follows every change, qualified or not, unless frozen
                if (mode != 2'd3 && is_diff[i]) prev_en[i*EW +: EW] <= en[i*EW +: EW];
                if (trg[i]) begin
                    q[i*DW +: DW] <= d[i*DW +: DW];
                    pend_data[i]  <= d[i*DW +: DW];
                end
                // A trigger on a channel being handed to the output keeps it pending
                pend[i] <= trg[i] || (pend[i] && !take[i]);
                overflow[i] <= clr_cnt ? 1'b0 : overflow[i] || (trg[i] && pend[i] && !take[i]);
                if (clr_cnt)
                    chg_cnt[i*CNTW +: CNTW] <= trg[i] ? CNTW'(1) : '0;
                else if (trg[i] && !(&chg_cnt[i*CNTW +: CNTW]))
                    chg_cnt[i*CNTW +: CNTW] <= chg_cnt[i*CNTW +: CNTW] + CNTW'(1);
            end
            if (load) begin
                evt_valid <= found;
                if (found) begin
                    evt_ch   <= sel;
                    evt_data <= pend_data[sel];
                    rr_ptr   <= (sel == PW'(CH - 1)) ? '0 : sel + 1'b1;
                end
            end
        end
    end
endmodule
